// File: rtl/pwm_dac.sv
// PWM output stage: takes 16-bit two's-complement samples, noise-shapes them down to RES bits
// with first-order error feedback, and emits a glitch-free PWM stream with period 2^RES-1 clocks.
module pwm_dac #(
    parameter int RES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_sample_stb,
    input  logic [15:0] i_din,
    input  logic        i_ovr_clr,
    output logic        o_pwm_out,
    output logic        o_period_start,
    output logic        o_overrun
);

    localparam int EW = 16 - RES;
    localparam logic [RES-1:0] CNT_LAST = RES'((2 ** RES) - 2);

    logic [RES-1:0] r_cnt;
    logic [RES-1:0] r_duty;
    logic [EW-1:0]  r_err;
    logic [15:0]    r_hold;
    logic           r_pending;
    logic           r_pwm;
    logic           r_overrun;

    logic           w_period_start;
    logic [15:0]    w_u;
    logic [16:0]    w_sum;
    logic [RES-1:0] w_duty_new;
    logic [RES-1:0] w_duty_eff;
    logic [EW-1:0]  w_err_new;
    logic           w_overrun_evt;

    // Offset-binary conversion plus error feedback; a carry out saturates to full-scale duty.
    always_comb begin
        w_period_start = i_en && (r_cnt == '0);
        w_u            = r_hold ^ 16'h8000;
        w_sum          = {1'b0, w_u} + {{(17 - EW){1'b0}}, r_err};
        if (w_sum[16]) begin
            w_duty_new = '1;
            w_err_new  = '0;
        end else begin
            w_duty_new = w_sum[15:16-RES];
            w_err_new  = w_sum[15-RES:0];
        end
        w_duty_eff     = (r_cnt == '0) ? w_duty_new : r_duty;
        w_overrun_evt  = i_sample_stb && r_pending && !w_period_start;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_err  <= '0;
            r_pwm  <= 1'b0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + RES'(1);
            r_pwm <= (r_cnt < w_duty_eff);
            if (w_period_start) begin
                r_duty <= w_duty_new;
                r_err  <= w_err_new;
            end
        end else begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end
    end

    // A strobe landing on a consuming period start re-arms pending instead of counting as lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold    <= 16'h0000;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_sample_stb) begin
                r_hold    <= i_din;
                r_pending <= 1'b1;
            end else if (w_period_start) begin
                r_pending <= 1'b0;
            end
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (i_ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_pwm_out      = r_pwm;
    assign o_period_start = w_period_start;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac (RES=8): vector table of held samples, hand-written corner sequences,
// and a randomized run, all checked cycle by cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pwm_dac;

    localparam int RES = 8;
    localparam int M   = 255;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_en;
    logic        i_sample_stb;
    logic [15:0] i_din;
    logic        i_ovr_clr;
    logic        o_pwm_out;
    logic        o_period_start;
    logic        o_overrun;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, advanced once per clock by applyStimulus.
    int          mPos;
    int          mDuty;
    int          mErr;
    logic [15:0] mHold;
    bit          mPending;
    bit          mOvr;
    bit          mPwm;

    typedef struct {
        bit          useStb;
        logic [15:0] din;
        int          duty0;
        int          duty1;
        int          duty2;
    } vec_t;

    vec_t vecs[8];

    pwm_dac #(.RES(RES)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_en           (i_en),
        .i_sample_stb   (i_sample_stb),
        .i_din          (i_din),
        .i_ovr_clr      (i_ovr_clr),
        .o_pwm_out      (o_pwm_out),
        .o_period_start (o_period_start),
        .o_overrun      (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPos     = 0;
        mDuty    = 0;
        mErr     = 0;
        mHold    = 16'h0000;
        mPending = 1'b0;
        mOvr     = 1'b0;
        mPwm     = 1'b0;
    endtask

    // Drive one cycle of inputs from a negedge, check outputs, then advance the model over the posedge.
    task automatic applyStimulus(input bit en, input bit stb, input logic [15:0] din, input bit clr);
        bit          ps;
        int          total;
        int          nDuty;
        int          nErr;
        int          curDuty;
        bit          evt;
        logic [15:0] u;
        i_en         = en;
        i_sample_stb = stb;
        i_din        = din;
        i_ovr_clr    = clr;
        #1;
        ps = en && (mPos == 0);
        checkOutput("periodStart", int'(o_period_start), int'(ps));
        checkOutput("pwmOut", int'(o_pwm_out), int'(mPwm));
        checkOutput("overrun", int'(o_overrun), int'(mOvr));
        nDuty = mDuty;
        nErr  = mErr;
        if (ps) begin
            u     = mHold ^ 16'h8000;
            total = int'(u) + mErr;
            if (total > 65535) begin
                nDuty = M;
                nErr  = 0;
            end else begin
                nDuty = total / 256;
                nErr  = total % 256;
            end
        end
        curDuty = ps ? nDuty : mDuty;
        evt     = stb && mPending && !ps;
        @(posedge i_clk);
        mPwm  = en && (mPos < curDuty);
        mPos  = en ? (mPos + 1) % M : 0;
        mDuty = nDuty;
        mErr  = nErr;
        if (evt)      mOvr = 1'b1;
        else if (clr) mOvr = 1'b0;
        if (stb)      mPending = 1'b1;
        else if (ps)  mPending = 1'b0;
        if (stb)      mHold = din;
        @(negedge i_clk);
    endtask

    task automatic doReset();
        i_rst_n      = 1'b0;
        i_en         = 1'b0;
        i_sample_stb = 1'b0;
        i_din        = 16'h0000;
        i_ovr_clr    = 1'b0;
        modelReset();
        repeat (2) @(negedge i_clk);
        checkOutput("resetPwm", int'(o_pwm_out), 0);
        checkOutput("resetPeriodStart", int'(o_period_start), 0);
        checkOutput("resetOverrun", int'(o_overrun), 0);
        i_rst_n = 1'b1;
    endtask

    task automatic waitPeriodStart();
        int guard = 0;
        while (mPos != 0 && guard < 2 * M) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
            guard++;
        end
        if (mPos != 0) checkOutput("waitPeriodStart", mPos, 0);
    endtask

    // Starts on cycle 1 of a period; counts high cycles over one full period of the lagged output.
    task automatic measure(output int highs);
        highs = 0;
        for (int c = 0; c < M; c++) begin
            if (o_pwm_out) highs++;
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        end
    endtask

    initial begin
        int h0;
        int h1;
        int h2;

        vecs[0] = '{1'b0, 16'h0000, 128, 128, 128};
        vecs[1] = '{1'b1, 16'h7FFF, 255, 255, 255};
        vecs[2] = '{1'b1, 16'h8000,   0,   0,   0};
        vecs[3] = '{1'b1, 16'h0080, 128, 129, 128};
        vecs[4] = '{1'b1, 16'hFFFF, 127, 128, 128};
        vecs[5] = '{1'b1, 16'h00FF, 128, 129, 129};
        vecs[6] = '{1'b1, 16'hC000,  64,  64,  64};
        vecs[7] = '{1'b1, 16'h4000, 192, 192, 192};

        i_rst_n      = 1'b0;
        i_en         = 1'b0;
        i_sample_stb = 1'b0;
        i_din        = 16'h0000;
        i_ovr_clr    = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < 8; i++) begin
            doReset();
            if (vecs[i].useStb) applyStimulus(1'b0, 1'b1, vecs[i].din, 1'b0);
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
            measure(h0);
            measure(h1);
            measure(h2);
            checkOutput($sformatf("vec%0d_period0", i), h0, vecs[i].duty0);
            checkOutput($sformatf("vec%0d_period1", i), h1, vecs[i].duty1);
            checkOutput($sformatf("vec%0d_period2", i), h2, vecs[i].duty2);
        end

        // Two strobes within one period: overrun, newest sample wins.
        doReset();
        repeat (20) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h8000, 1'b0);
        repeat (9) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0);
        checkOutput("overrunSet", int'(o_overrun), 1);
        waitPeriodStart();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        measure(h0);
        checkOutput("overrunNewestDin", h0, 255);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("overrunCleared", int'(o_overrun), 0);

        // Clear and a fresh overrun in the same cycle: the event wins.
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b1);
        checkOutput("overrunClrCollision", int'(o_overrun), 1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("overrunCleared2", int'(o_overrun), 0);

        // Strobe on a consuming period start with a sample already pending.
        waitPeriodStart();
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0);
        checkOutput("stbAtPeriodStart", int'(o_overrun), 0);

        // Enable dropped mid-period, then restored.
        repeat (50) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("pwmHighMidPeriod", int'(o_pwm_out), 1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("enLowPwm", int'(o_pwm_out), 0);
        checkOutput("enLowPeriodStart", int'(o_period_start), 0);
        repeat (5) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        i_en = 1'b1;
        #1;
        checkOutput("reenablePeriodStart", int'(o_period_start), 1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        measure(h0);
        checkOutput("reenableDuty", h0, 255);

        // Asynchronous reset mid-period with the output high and overrun set.
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("preResetPwm", int'(o_pwm_out), 1);
        checkOutput("preResetOverrun", int'(o_overrun), 1);
        #2;
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        #1;
        checkOutput("asyncRstPwm", int'(o_pwm_out), 0);
        checkOutput("asyncRstOverrun", int'(o_overrun), 0);
        modelReset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_en    = 1'b1;
        #1;
        checkOutput("postResetPeriodStart", int'(o_period_start), 1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        measure(h0);
        checkOutput("postResetMidscale", h0, 128);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 149) == 0),
                          16'($urandom),
                          ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
